cplx_integrate_dump: RTL and testbench

//  Downstream of the 3-DSP complex multiplier. Sums N consecutive complex products (integrate),

---
 rtl/cplx_integrate_dump_pkg.sv | 51 +++++
 rtl/cplx_integrate_dump_if.sv | 24 ++
 rtl/cplx_integrate_dump_round_sat.sv | 23 ++
 rtl/cplx_integrate_dump.sv | 118 +++++++++++
 tb/tb_cplx_integrate_dump.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cplx_integrate_dump_pkg.sv
// Shared widths and round/saturate helpers for the complex integrate-and-dump block.
// Saturation is used only when CPLX_ID_SAT_EN is defined.
package cplx_integrate_dump_pkg;

    localparam int IWIDTH = 33;
    localparam int CWIDTH = 10;
    localparam int SWIDTH = 5;
    localparam int OWIDTH = 16;
    localparam int ACC_W  = IWIDTH + CWIDTH;

    // One guard bit above ACC_W so that adding the rounding bias cannot wrap.
    function automatic logic signed [ACC_W:0] round_shift(
        input logic signed [ACC_W-1:0] v,
        input logic [SWIDTH-1:0]       sh
    );
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] bias;
        ext  = {v[ACC_W-1], v};
        bias = '0;
        if (sh != '0) begin
            bias = {{ACC_W{1'b0}}, 1'b1} <<< (sh - SWIDTH'(1));
        end
        return (ext + bias) >>> sh;
    endfunction

    function automatic logic signed [ACC_W:0] sat_bound(input logic want_max);
        logic signed [ACC_W:0] b;
        if (want_max) begin
            b = '0;
            b[OWIDTH-2:0] = '1;
        end else begin
            b = '1;
            b[OWIDTH-2:0] = '0;
        end
        return b;
    endfunction

    function automatic logic signed [OWIDTH-1:0] sat_out(input logic signed [ACC_W:0] r);
        logic signed [ACC_W:0] hi;
        logic signed [ACC_W:0] lo;
        hi = sat_bound(1'b1);
        lo = sat_bound(1'b0);
        if (r > hi) begin
            return hi[OWIDTH-1:0];
        end else if (r < lo) begin
            return lo[OWIDTH-1:0];
        end
        return r[OWIDTH-1:0];
    endfunction

endpackage

// File: rtl/cplx_integrate_dump_if.sv
// Sample input and valid/ready result bus of the complex integrate-and-dump block.
interface cplx_integrate_dump_if
    import cplx_integrate_dump_pkg::*;
    ();

    logic                     in_valid;
    logic signed [IWIDTH-1:0] in_re;
    logic signed [IWIDTH-1:0] in_im;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OWIDTH-1:0] out_re;
    logic signed [OWIDTH-1:0] out_im;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  out_valid, out_re, out_im
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output out_valid, out_re, out_im
    );

endinterface

// File: rtl/cplx_integrate_dump_round_sat.sv
// Round-half-up right shift of one accumulator part, then reduction to OWIDTH.
// CPLX_ID_SAT_EN selects saturation; otherwise the low OWIDTH bits are kept.
module cid_round_sat
    import cplx_integrate_dump_pkg::*;
(
    input  logic signed [ACC_W-1:0]  sum_i,
    input  logic [SWIDTH-1:0]        shift_i,
    output logic signed [OWIDTH-1:0] res_o
);

    logic signed [ACC_W:0] r;

    assign r = round_shift(sum_i, shift_i);

`ifdef CPLX_ID_SAT_EN
    assign res_o = sat_out(r);
`else
    logic unused_hi;
    assign unused_hi = ^r[ACC_W:OWIDTH];
    assign res_o     = r[OWIDTH-1:0];
`endif

endmodule

// File: rtl/cplx_integrate_dump.sv
// Integrates acc_len complex products and dumps one scaled result over valid/ready.
// Output reduction saturates when CPLX_ID_SAT_EN is defined, wraps otherwise.
module cplx_integrate_dump
    import cplx_integrate_dump_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic [CWIDTH-1:0]   acc_len,
    input  logic [SWIDTH-1:0]   shift,
    cplx_integrate_dump_if.slave bus,
    output logic                ovf
);

    logic [CWIDTH-1:0]        cnt_q;
    logic [CWIDTH-1:0]        len_q;
    logic [SWIDTH-1:0]        shift_q;
    logic signed [ACC_W-1:0]  acc_re_q, acc_im_q;
    logic signed [ACC_W-1:0]  acc_re_d, acc_im_d;
    logic signed [ACC_W-1:0]  sum_re_q, sum_im_q;
    logic [SWIDTH-1:0]        dump_shift_q;
    logic                     dump_v_q;
    logic                     out_valid_q;
    logic signed [OWIDTH-1:0] out_re_q, out_im_q;
    logic                     ovf_q;

    logic                     take;
    logic                     first;
    logic                     last;
    logic [CWIDTH-1:0]        eff_len;
    logic [SWIDTH-1:0]        eff_shift;
    logic signed [ACC_W-1:0]  in_re_x, in_im_x;
    logic signed [OWIDTH-1:0] rs_re, rs_im;

    // On the first sample of a frame the live acc_len/shift apply, so len=1 dumps at once.
    always_comb begin
        take      = bus.in_valid && !clear;
        first     = (cnt_q == '0);
        eff_len   = first ? acc_len : len_q;
        eff_shift = first ? shift : shift_q;
        last      = (cnt_q == (eff_len - CWIDTH'(1)));
        in_re_x   = {{CWIDTH{bus.in_re[IWIDTH-1]}}, bus.in_re};
        in_im_x   = {{CWIDTH{bus.in_im[IWIDTH-1]}}, bus.in_im};
        acc_re_d  = first ? in_re_x : acc_re_q + in_re_x;
        acc_im_d  = first ? in_im_x : acc_im_q + in_im_x;
    end

    cid_round_sat u_rs_re (
        .sum_i   (sum_re_q),
        .shift_i (dump_shift_q),
        .res_o   (rs_re)
    );

    cid_round_sat u_rs_im (
        .sum_i   (sum_im_q),
        .shift_i (dump_shift_q),
        .res_o   (rs_im)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            len_q        <= '0;
            shift_q      <= '0;
            acc_re_q     <= '0;
            acc_im_q     <= '0;
            sum_re_q     <= '0;
            sum_im_q     <= '0;
            dump_shift_q <= '0;
            dump_v_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_re_q     <= '0;
            out_im_q     <= '0;
            ovf_q        <= 1'b0;
        end else begin
            dump_v_q <= 1'b0;
            if (clear) begin
                cnt_q <= '0;
            end else if (take) begin
                if (first) begin
                    len_q   <= acc_len;
                    shift_q <= shift;
                end
                acc_re_q <= acc_re_d;
                acc_im_q <= acc_im_d;
                if (last) begin
                    cnt_q        <= '0;
                    sum_re_q     <= acc_re_d;
                    sum_im_q     <= acc_im_d;
                    dump_shift_q <= eff_shift;
                    dump_v_q     <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CWIDTH'(1);
                end
            end

            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            // A result arriving while the held one is not being taken is lost.
            if (dump_v_q && !clear) begin
                if (!out_valid_q || bus.out_ready) begin
                    out_valid_q <= 1'b1;
                    out_re_q    <= rs_re;
                    out_im_q    <= rs_im;
                end else begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
    assign ovf           = ovf_q;

endmodule

// File: tb/tb_cplx_integrate_dump.sv
// Directed and randomized bench for cplx_integrate_dump against a frame-sum reference model.
module tb_cplx_integrate_dump;
    import cplx_integrate_dump_pkg::*;

    logic              clk;
    logic              rst;
    logic              clear;
    logic [CWIDTH-1:0] acc_len;
    logic [SWIDTH-1:0] shift;
    logic              ovf;

    int n_cmp;
    int n_mis;
    logic mon_en;
    logic signed [63:0] exp_re[$];
    logic signed [63:0] exp_im[$];

    cplx_integrate_dump_if bus_if ();

    cplx_integrate_dump dut (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .acc_len (acc_len),
        .shift   (shift),
        .bus     (bus_if),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected output of one frame: sum, round half up, shift, reduce to OWIDTH.
    function automatic logic signed [63:0] ref_out(input longint sum, input int sh);
        longint r;
        logic signed [OWIDTH-1:0] w;
        r = sum;
        if (sh > 0) r = r + (longint'(1) << (sh - 1));
        r = r >>> sh;
`ifdef CPLX_ID_SAT_EN
        if (r > longint'((1 << (OWIDTH - 1)) - 1)) r = longint'((1 << (OWIDTH - 1)) - 1);
        if (r < -longint'(1 << (OWIDTH - 1))) r = -longint'(1 << (OWIDTH - 1));
`endif
        w = r[OWIDTH-1:0];
        return w;
    endfunction

    task automatic cyc(input logic v, input int re, input int im, input logic clr);
        @(negedge clk);
        bus_if.in_valid = v;
        bus_if.in_re    = IWIDTH'(re);
        bus_if.in_im    = IWIDTH'(im);
        clear           = clr;
    endtask

    task automatic idle();
        cyc(1'b0, 0, 0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en && bus_if.out_valid && bus_if.out_ready) begin
            if (exp_re.size() == 0) begin
                check("rnd_unexpected_valid", bus_if.out_valid, 0);
            end else begin
                check("rnd_re", bus_if.out_re, exp_re.pop_front());
                check("rnd_im", bus_if.out_im, exp_im.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int len;
        int sh;
        int gap;
        longint sre;
        longint sim;
        logic signed [IWIDTH-1:0] rre;
        logic signed [IWIDTH-1:0] rim;

        n_cmp = 0;
        n_mis = 0;
        mon_en = 1'b0;
        rst = 1'b1;
        clear = 1'b0;
        acc_len = '0;
        shift = '0;
        bus_if.in_valid = 1'b0;
        bus_if.in_re = '0;
        bus_if.in_im = '0;
        bus_if.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_out_valid", bus_if.out_valid, 0);
        check("rst_out_re", bus_if.out_re, 0);
        check("rst_out_im", bus_if.out_im, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;

        // Test 1: len=4, shift=0, (1,-1) x4
        acc_len = CWIDTH'(4);
        shift = '0;
        repeat (4) cyc(1'b1, 1, -1, 1'b0);
        idle();
        check("t1_latency_valid", bus_if.out_valid, 0);
        idle();
        check("t1_valid", bus_if.out_valid, 1);
        check("t1_re", bus_if.out_re, 4);
        check("t1_im", bus_if.out_im, -4);
        check("t1_ovf", ovf, 0);
        idle();
        check("t1_consumed", bus_if.out_valid, 0);

        // Test 2: len=3, shift=2, round half up
        acc_len = CWIDTH'(3);
        shift = SWIDTH'(2);
        cyc(1'b1, 5, 6, 1'b0);
        cyc(1'b1, 0, 0, 1'b0);
        cyc(1'b1, 0, 1, 1'b0);
        idle();
        idle();
        check("t2_valid", bus_if.out_valid, 1);
        check("t2_re", bus_if.out_re, 1);
        check("t2_im", bus_if.out_im, 2);
        idle();

        // Test 3: output reduction beyond OWIDTH
        acc_len = CWIDTH'(2);
        shift = '0;
        repeat (2) cyc(1'b1, 30000, -30000, 1'b0);
        idle();
        idle();
        check("t3_valid", bus_if.out_valid, 1);
`ifdef CPLX_ID_SAT_EN
        check("t3_re", bus_if.out_re, 32767);
        check("t3_im", bus_if.out_im, -32768);
`else
        check("t3_re", bus_if.out_re, -5536);
        check("t3_im", bus_if.out_im, 5536);
`endif
        idle();

        // Test 4: len=1 with a stalled output; second result dropped
        acc_len = CWIDTH'(1);
        bus_if.out_ready = 1'b0;
        cyc(1'b1, 11, -11, 1'b0);
        cyc(1'b1, 22, -22, 1'b0);
        idle();
        check("t4_valid_held", bus_if.out_valid, 1);
        check("t4_re_first", bus_if.out_re, 11);
        check("t4_ovf_before", ovf, 0);
        idle();
        check("t4_ovf_set", ovf, 1);
        check("t4_re_kept", bus_if.out_re, 11);
        check("t4_im_kept", bus_if.out_im, -11);
        bus_if.out_ready = 1'b1;
        idle();
        check("t4_accepted", bus_if.out_valid, 0);
        check("t4_ovf_sticky", ovf, 1);

        // Test 5: clear mid-frame, sample under clear excluded
        acc_len = CWIDTH'(8);
        repeat (5) cyc(1'b1, 3, 3, 1'b0);
        cyc(1'b1, 100, 100, 1'b1);
        repeat (8) cyc(1'b1, 1, 1, 1'b0);
        idle();
        idle();
        check("t5_valid", bus_if.out_valid, 1);
        check("t5_re", bus_if.out_re, 8);
        check("t5_im", bus_if.out_im, 8);
        idle();
        check("t5_single", bus_if.out_valid, 0);

        // Test 6: reset mid-frame while a result is held
        bus_if.out_ready = 1'b0;
        acc_len = CWIDTH'(1);
        cyc(1'b1, 50, 50, 1'b0);
        idle();
        idle();
        check("t6_held_before_rst", bus_if.out_valid, 1);
        acc_len = CWIDTH'(4);
        repeat (3) cyc(1'b1, 7, 7, 1'b0);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", bus_if.out_valid, 0);
        check("t6_rst_re", bus_if.out_re, 0);
        check("t6_rst_im", bus_if.out_im, 0);
        check("t6_rst_ovf", ovf, 0);
        rst = 1'b0;
        bus_if.out_ready = 1'b1;
        acc_len = CWIDTH'(2);
        cyc(1'b1, 4, -6, 1'b0);
        cyc(1'b1, 5, 2, 1'b0);
        idle();
        idle();
        check("t6_valid", bus_if.out_valid, 1);
        check("t6_re", bus_if.out_re, 9);
        check("t6_im", bus_if.out_im, -4);
        idle();

        // Randomized frames against the reference model
        mon_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 6);
            sh = $urandom_range(0, ACC_W - OWIDTH);
            sre = 0;
            sim = 0;
            for (int k = 0; k < len; k++) begin
                gap = $urandom_range(0, 2);
                repeat (gap) idle();
                @(negedge clk);
                if (k == 0) begin
                    acc_len = CWIDTH'(len);
                    shift = SWIDTH'(sh);
                end
                rre = IWIDTH'({$urandom, $urandom});
                rim = IWIDTH'({$urandom, $urandom});
                bus_if.in_valid = 1'b1;
                bus_if.in_re = rre;
                bus_if.in_im = rim;
                clear = 1'b0;
                sre = sre + longint'(rre);
                sim = sim + longint'(rim);
            end
            exp_re.push_back(ref_out(sre, sh));
            exp_im.push_back(ref_out(sim, sh));
        end
        idle();
        for (int i = 0; i < 20 && exp_re.size() != 0; i++) idle();
        check("rnd_drain_empty", exp_re.size(), 0);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
